// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle data-memory access stage that sits directly behind the ALU.
// The ALU result is the effective address of an RV32I load or store, and rs2
// is the store data. The unit drives a request/grant/response memory bus,
// steers bytes onto the right lanes, sign/zero-extends load results and
// holds the core stalled until the access completes. Misaligned addresses,
// illegal size encodings and bus timeouts complete with an error flag.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid             memory instruction present, operands stable to o_done
//   i_is_store          1 = store, 0 = load
//   i_funct3            RV32I size/sign field (B, H, W, BU, HU)
//   i_addr              effective address
//   i_store_data        rs2 value
//   o_stall             i_valid & ~o_done, freezes PC and register writeback
//   o_done              one-cycle completion pulse
//   o_err               error flag, valid with o_done
//   o_load_data         extended load result, valid with o_done for loads
//   o_mem_req/we/addr   bus request, write enable, word-aligned address
//   o_mem_wdata/wstrb   lane-replicated store data and byte strobes
//   i_mem_gnt           request accepted
//   i_mem_rvalid        read data valid / write acknowledge
//   i_mem_rdata         read data
//
// Only DATA_LEN = 32 is supported. TIMEOUT = 0 disables the response
// timeout; otherwise TIMEOUT must be below 2**CNT_W.
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic                i_is_store,
    input  logic [2:0]          i_funct3,
    input  logic [DATA_LEN-1:0] i_addr,
    input  logic [DATA_LEN-1:0] i_store_data,
    output logic                o_stall,
    output logic                o_done,
    output logic                o_err,
    output logic [DATA_LEN-1:0] o_load_data,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_LEN-1:0] o_mem_addr,
    output logic [DATA_LEN-1:0] o_mem_wdata,
    output logic [3:0]          o_mem_wstrb,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_LEN-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    // The counter value seen in the last permitted RESP cycle: the counter is
    // cleared on grant, so the TIMEOUT-th RESP cycle observes TIMEOUT-1.
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST_CNT   = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t                state_q,    state_d;
    logic [2:0]            funct3_q,   funct3_d;
    logic [1:0]            addrLo_q,   addrLo_d;
    logic                  isStore_q,  isStore_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;
    logic [DATA_LEN-1:0]   loadData_q, loadData_d;
    logic                  memReq_q,   memReq_d;
    logic                  memWe_q,    memWe_d;
    logic [DATA_LEN-1:0]   memAddr_q,  memAddr_d;
    logic [DATA_LEN-1:0]   memWdata_q, memWdata_d;
    logic [3:0]            memWstrb_q, memWstrb_d;

    logic                  illegal;
    logic                  misaligned;
    logic [DATA_LEN-1:0]   steerWdata;
    logic [3:0]            steerWstrb;
    logic [DATA_LEN-1:0]   shifted;
    logic [DATA_LEN-1:0]   extData;

    // Issue-time decode of the incoming instruction. funct3[1:0] = 11 has no
    // access size at all; the unsigned bit is meaningless for stores and for
    // word loads. Store data is replicated across every lane so the strobes
    // alone select which bytes the memory writes.
    always_comb begin
        illegal    = (i_funct3[1:0] == 2'b11) ||
                     (i_funct3[2] && (i_is_store || (i_funct3[1:0] == 2'b10)));
        misaligned = 1'b0;
        steerWdata = '0;
        steerWstrb = 4'b0000;
        case (i_funct3[1:0])
            2'b00: begin
                steerWdata = {4{i_store_data[7:0]}};
                steerWstrb = 4'b0001 << i_addr[1:0];
            end
            2'b01: begin
                misaligned = i_addr[0];
                steerWdata = {2{i_store_data[15:0]}};
                steerWstrb = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misaligned = |i_addr[1:0];
                steerWdata = i_store_data;
                steerWstrb = 4'b1111;
            end
            default: begin
                misaligned = 1'b0;
            end
        endcase
    end

    // Load extraction from the response word: shift the addressed byte or
    // halfword down to bit 0, then extend according to the latched funct3.
    always_comb begin
        shifted = i_mem_rdata >> {addrLo_q, 3'b000};
        case (funct3_q)
            3'b000:  extData = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  extData = {24'h000000, shifted[7:0]};
            3'b001:  extData = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  extData = {16'h0000, shifted[15:0]};
            default: extData = i_mem_rdata;
        endcase
    end

    // Next-state and registered-output logic. Everything holds by default;
    // done and err are pulses, so they default low and are raised only on
    // the transition into DONE.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addrLo_d   = addrLo_q;
        isStore_d  = isStore_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        loadData_d = loadData_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWstrb_d = memWstrb_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    funct3_d   = i_funct3;
                    addrLo_d   = i_addr[1:0];
                    isStore_d  = i_is_store;
                    memAddr_d  = {i_addr[DATA_LEN-1:2], 2'b00};
                    memWdata_d = steerWdata;
                    memWstrb_d = i_is_store ? steerWstrb : 4'b0000;
                    if (illegal || misaligned) begin
                        memWe_d = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        memWe_d  = i_is_store;
                        memReq_d = 1'b1;
                        state_d  = REQ;
                    end
                end
            end

            REQ: begin
                if (i_mem_gnt) begin
                    memReq_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RESP;
                end
            end

            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_mem_rvalid) begin
                    if (!isStore_q) begin
                        loadData_d = extData;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (TIMEOUT_EN && (cnt_q == LAST_CNT)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any bus transaction in
    // flight; the memory side shares this reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            addrLo_q   <= 2'b00;
            isStore_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            loadData_q <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWstrb_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addrLo_q   <= addrLo_d;
            isStore_q  <= isStore_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            loadData_q <= loadData_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWstrb_q <= memWstrb_d;
        end
    end

    assign o_stall     = i_valid & ~done_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_load_data = loadData_q;
    assign o_mem_req   = memReq_q;
    assign o_mem_we    = memWe_q;
    assign o_mem_addr  = memAddr_q;
    assign o_mem_wdata = memWdata_q;
    assign o_mem_wstrb = memWstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit (built with TIMEOUT = 4). A driver
// task plays both the core and the memory: it presents one instruction at a
// negedge, answers the bus with a programmable grant delay and response
// delay, and records what the DUT did. Each test task then compares those
// observations against constants or against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TIMEOUT = 4;
    localparam int MAX_CYC = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = '0;
    logic [31:0] i_store_data = '0;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_stall, o_done, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_load_data, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;

    int testsRun = 0;
    int testsFailed = 0;

    // Observations from the most recent drive_op call
    int          obsDone;
    logic        obsErr;
    logic [31:0] obsLoad;
    logic        obsReq;
    logic        obsWe;
    logic [31:0] obsAddr, obsWdata;
    logic [3:0]  obsWstrb;
    int          obsStall;
    logic        obsStallAtDone;
    logic        obsBusMoved;

    load_store_unit #(
        .DATA_LEN (32),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_load_data  (o_load_data),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Hard stop in case the bench itself deadlocks
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one instruction (called at a negedge) and act as the memory.
    // gntDelay = REQ cycles without grant before the grant; rvDelay = RESP
    // cycles without rvalid before rvalid, or -1 for a response that never
    // comes. Cycle 1 is the cycle in which i_valid is first sampled.
    task automatic drive_op(input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata,
                            input int gntDelay, input int rvDelay);
        int   reqCount = 0;
        int   respIdx = 0;
        logic granted = 1'b0;
        logic finished = 1'b0;
        obsDone = -1; obsErr = 1'b0; obsLoad = '0; obsReq = 1'b0;
        obsWe = 1'b0; obsAddr = '0; obsWdata = '0; obsWstrb = '0;
        obsStall = 0; obsStallAtDone = 1'b0; obsBusMoved = 1'b0;
        i_valid = 1'b1; i_is_store = st; i_funct3 = f3;
        i_addr = addr; i_store_data = sd;
        for (int cyc = 1; cyc <= MAX_CYC && !finished; cyc++) begin
            #1;
            i_mem_gnt = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata = $urandom();
            if (o_done) begin
                finished = 1'b1;
                obsDone = cyc;
                obsErr = o_err;
                obsLoad = o_load_data;
                obsStallAtDone = o_stall;
            end else begin
                if (o_stall) obsStall++;
                if (granted) begin
                    respIdx++;
                    if (rvDelay >= 0 && respIdx == rvDelay + 1) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata = rdata;
                    end
                end else if (o_mem_req) begin
                    if (!obsReq) begin
                        obsReq = 1'b1; obsWe = o_mem_we; obsAddr = o_mem_addr;
                        obsWdata = o_mem_wdata; obsWstrb = o_mem_wstrb;
                    end else if (o_mem_we !== obsWe || o_mem_addr !== obsAddr ||
                                 o_mem_wdata !== obsWdata || o_mem_wstrb !== obsWstrb) begin
                        obsBusMoved = 1'b1;
                    end
                    reqCount++;
                    if (reqCount > gntDelay) begin
                        i_mem_gnt = 1'b1;
                        granted = 1'b1;
                    end
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        i_valid = 1'b0;
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: derives the outcome of one instruction from the
    // architectural rules (access size, alignment, lane arithmetic, delays).
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [31:0] rdata,
                                  input int gntDelay, input int rvDelay,
                                  inout logic [31:0] lastLoad,
                                  output int expDone, output logic expErr,
                                  output logic expReq, output logic [31:0] expWdata,
                                  output logic [3:0] expWstrb);
        int          size, off, respCycles;
        logic        bad;
        logic [31:0] v, mask;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(addr[1:0]);
        bad = (f3[1:0] == 2'b11) || (f3[2] && (st || f3[1:0] == 2'b10)) || (off % size != 0);
        expReq = !bad;
        expWdata = '0;
        expWstrb = '0;
        if (bad) begin
            expErr = 1'b1;
            expDone = 2;
            return;
        end
        if (st) begin
            for (int i = 0; i < 4; i++) expWdata[8*i +: 8] = sd[8*(i % size) +: 8];
            expWstrb = 4'(((1 << size) - 1) << off);
        end
        if (rvDelay >= 0 && rvDelay < TIMEOUT) begin
            respCycles = rvDelay + 1;
            expErr = 1'b0;
        end else begin
            respCycles = TIMEOUT;
            expErr = 1'b1;
        end
        expDone = 1 + gntDelay + 1 + respCycles + 1;
        if (!st && !expErr) begin
            v = rdata >> (8 * off);
            if (size < 4) begin
                mask = (32'h1 << (8 * size)) - 32'h1;
                v = v & mask;
                if (!f3[2] && v[8*size-1]) v = v | ~mask;
            end
            lastLoad = v;
        end
    endfunction

    // Reset state of every output, with i_valid raised to exercise o_stall
    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        i_valid = 1'b1;
        #1;
        testsRun++;
        if ({o_done, o_err, o_mem_req, o_mem_we, o_mem_wstrb} !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {o_done, o_err, o_mem_req, o_mem_we, o_mem_wstrb});
        end
        testsRun++;
        if ({o_load_data, o_mem_addr, o_mem_wdata} !== 96'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {o_load_data, o_mem_addr, o_mem_wdata});
        end
        testsRun++;
        if (o_stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_stall: got %b expected 1", o_stall);
        end
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          expDone;
        logic        expErr;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expWstrb;
        logic [31:0] expLoad;
    } dirCase_t;

    function automatic dirCase_t mkCase(logic st, logic [2:0] f3, logic [31:0] addr,
                                        logic [31:0] sd, logic [31:0] rdata, int expDone,
                                        logic expErr, logic [31:0] expAddr,
                                        logic [31:0] expWdata, logic [3:0] expWstrb,
                                        logic [31:0] expLoad);
        dirCase_t c;
        c.st = st; c.f3 = f3; c.addr = addr; c.sd = sd; c.rdata = rdata;
        c.expDone = expDone; c.expErr = expErr; c.expReq = !expErr;
        c.expAddr = expAddr; c.expWdata = expWdata; c.expWstrb = expWstrb;
        c.expLoad = expLoad;
        return c;
    endfunction

    // Fixed loads, stores and error cases with hand-computed expectations
    task automatic test_directed;
        dirCase_t cases[10];
        cases[0] = mkCase(0, 3'b010, 32'h1000, 0, 32'hDEADBEEF, 4, 0, 32'h1000, 0, 4'b0000, 32'hDEADBEEF);
        cases[1] = mkCase(0, 3'b000, 32'h1003, 0, 32'h80FF1234, 4, 0, 32'h1000, 0, 4'b0000, 32'hFFFFFF80);
        cases[2] = mkCase(0, 3'b100, 32'h1003, 0, 32'h80FF1234, 4, 0, 32'h1000, 0, 4'b0000, 32'h00000080);
        cases[3] = mkCase(0, 3'b101, 32'h1002, 0, 32'h80FF1234, 4, 0, 32'h1000, 0, 4'b0000, 32'h000080FF);
        cases[4] = mkCase(0, 3'b001, 32'h1002, 0, 32'h80FF1234, 4, 0, 32'h1000, 0, 4'b0000, 32'hFFFF80FF);
        cases[5] = mkCase(1, 3'b000, 32'h2001, 32'h000000A5, 32'h5A5A5A5A, 4, 0, 32'h2000, 32'hA5A5A5A5, 4'b0010, 32'hFFFF80FF);
        cases[6] = mkCase(1, 3'b001, 32'h2002, 32'h00001234, 32'h5A5A5A5A, 4, 0, 32'h2000, 32'h12341234, 4'b1100, 32'hFFFF80FF);
        cases[7] = mkCase(0, 3'b010, 32'h1002, 0, 32'h5A5A5A5A, 2, 1, 0, 0, 4'b0000, 32'hFFFF80FF);
        cases[8] = mkCase(1, 3'b001, 32'h1001, 32'h00001234, 32'h5A5A5A5A, 2, 1, 0, 0, 4'b0000, 32'hFFFF80FF);
        cases[9] = mkCase(0, 3'b011, 32'h1000, 0, 32'h5A5A5A5A, 2, 1, 0, 0, 4'b0000, 32'hFFFF80FF);
        for (int i = 0; i < 10; i++) begin
            drive_op(cases[i].st, cases[i].f3, cases[i].addr, cases[i].sd, cases[i].rdata, 0, 0);
            testsRun++;
            if (obsDone !== cases[i].expDone) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_done_cycle: got %0d expected %0d", i, obsDone, cases[i].expDone);
            end
            testsRun++;
            if (obsErr !== cases[i].expErr) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_err: got %b expected %b", i, obsErr, cases[i].expErr);
            end
            testsRun++;
            if (obsLoad !== cases[i].expLoad) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_load: got %h expected %h", i, obsLoad, cases[i].expLoad);
            end
            testsRun++;
            if (obsReq !== cases[i].expReq) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_req: got %b expected %b", i, obsReq, cases[i].expReq);
            end
            testsRun++;
            if (obsStall !== cases[i].expDone - 1 || obsStallAtDone !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL dir%0d_stall: got %0d cycles/%b at done expected %0d/0",
                         i, obsStall, obsStallAtDone, cases[i].expDone - 1);
            end
            if (cases[i].expReq) begin
                testsRun++;
                if ({obsWe, obsAddr, obsWstrb} !== {cases[i].st, cases[i].expAddr, cases[i].expWstrb}) begin
                    testsFailed++;
                    $display("[TB] FAIL dir%0d_bus: got we=%b addr=%h wstrb=%b expected we=%b addr=%h wstrb=%b",
                             i, obsWe, obsAddr, obsWstrb, cases[i].st, cases[i].expAddr, cases[i].expWstrb);
                end
                if (cases[i].st) begin
                    testsRun++;
                    if (obsWdata !== cases[i].expWdata) begin
                        testsFailed++;
                        $display("[TB] FAIL dir%0d_wdata: got %h expected %h", i, obsWdata, cases[i].expWdata);
                    end
                end
            end
        end
    endtask

    // Late grant followed by a missing response, then a response on the last
    // permitted RESP cycle
    task automatic test_timeout;
        drive_op(0, 3'b010, 32'h3000, 0, 32'h11111111, 5, -1);
        testsRun++;
        if (obsDone !== 12 || obsErr !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL timeout_err: got done=%0d err=%b expected done=12 err=1", obsDone, obsErr);
        end
        testsRun++;
        if (obsLoad !== 32'hFFFF80FF) begin
            testsFailed++;
            $display("[TB] FAIL timeout_load_kept: got %h expected ffff80ff", obsLoad);
        end
        drive_op(0, 3'b010, 32'h3000, 0, 32'hCAFEF00D, 5, 3);
        testsRun++;
        if (obsDone !== 12 || obsErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_edge_ok: got done=%0d err=%b expected done=12 err=0", obsDone, obsErr);
        end
        testsRun++;
        if (obsLoad !== 32'hCAFEF00D) begin
            testsFailed++;
            $display("[TB] FAIL timeout_edge_load: got %h expected cafef00d", obsLoad);
        end
    endtask

    // Asynchronous reset while waiting for a response
    task automatic test_async_reset;
        drive_op(0, 3'b010, 32'h1000, 0, 32'h600DF00D, 0, 0);
        testsRun++;
        if (obsLoad !== 32'h600DF00D) begin
            testsFailed++;
            $display("[TB] FAIL arst_preload: got %h expected 600df00d", obsLoad);
        end
        i_valid = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h1000;
        @(posedge clk);
        @(negedge clk);
        #1;
        testsRun++;
        if (o_mem_req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL arst_req_issued: got %b expected 1", o_mem_req);
        end
        i_mem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({o_mem_req, o_done, o_err} !== 3'b000 || o_load_data !== 32'h0 || o_mem_addr !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL arst_clear: got req=%b done=%b err=%b load=%h addr=%h expected all 0",
                     o_mem_req, o_done, o_err, o_load_data, o_mem_addr);
        end
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_op(0, 3'b010, 32'h1004, 0, 32'h12345678, 0, 0);
        testsRun++;
        if (obsDone !== 4 || obsErr !== 1'b0 || obsLoad !== 32'h12345678) begin
            testsFailed++;
            $display("[TB] FAIL arst_recover: got done=%0d err=%b load=%h expected 4/0/12345678",
                     obsDone, obsErr, obsLoad);
        end
    endtask

    // Back-to-back random instructions with random bus delays
    task automatic test_back_to_back_random;
        logic [31:0] lastLoad, addr, sd, rdata, expWdata;
        logic [2:0]  f3;
        logic [3:0]  expWstrb;
        logic        st, expErr, expReq;
        int          gd, rd, expDone;
        drive_op(0, 3'b010, 32'h40, 0, 32'h0BADCAFE, 0, 0);
        lastLoad = 32'h0BADCAFE;
        for (int n = 0; n < 200; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (st && f3 == 3'b011) f3 = 3'b110;
            addr = $urandom();
            sd = $urandom();
            rdata = $urandom();
            gd = int'($urandom_range(0, 3));
            rd = int'($urandom_range(0, TIMEOUT + 2)) - 1;
            model(st, f3, addr, sd, rdata, gd, rd, lastLoad, expDone, expErr, expReq, expWdata, expWstrb);
            drive_op(st, f3, addr, sd, rdata, gd, rd);
            testsRun++;
            if (obsDone !== expDone || obsErr !== expErr) begin
                testsFailed++;
                $display("[TB] FAIL rnd%0d_done: st=%b f3=%b addr=%h got done=%0d err=%b expected done=%0d err=%b",
                         n, st, f3, addr, obsDone, obsErr, expDone, expErr);
            end
            testsRun++;
            if (obsLoad !== lastLoad) begin
                testsFailed++;
                $display("[TB] FAIL rnd%0d_load: f3=%b addr=%h rdata=%h got %h expected %h",
                         n, f3, addr, rdata, obsLoad, lastLoad);
            end
            testsRun++;
            if (obsReq !== expReq || obsBusMoved !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rnd%0d_req: got req=%b moved=%b expected req=%b moved=0",
                         n, obsReq, obsBusMoved, expReq);
            end
            if (expReq) begin
                testsRun++;
                if ({obsWe, obsAddr, obsWstrb} !== {st, addr[31:2], 2'b00, expWstrb}) begin
                    testsFailed++;
                    $display("[TB] FAIL rnd%0d_bus: got we=%b addr=%h wstrb=%b expected we=%b addr=%h wstrb=%b",
                             n, obsWe, obsAddr, obsWstrb, st, {addr[31:2], 2'b00}, expWstrb);
                end
                if (st) begin
                    testsRun++;
                    if (obsWdata !== expWdata) begin
                        testsFailed++;
                        $display("[TB] FAIL rnd%0d_wdata: f3=%b sd=%h got %h expected %h",
                                 n, f3, sd, obsWdata, expWdata);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_async_reset();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
